clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter_pkg.sv | 22 ++
 rtl/edge_sync.sv | 37 +++
 rtl/clock_period_meter.sv | 134 +++++++++++++
 tb/tb_clock_period_meter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/clock_period_meter_pkg.sv
// Shared project package: meter FSM encoding plus default widths/limits
// for the period meter and the clock divider that typically feeds it.
package clock_period_meter_pkg;

    localparam int METER_N     = 16;
    localparam int DIV_N       = 16;
    localparam int DIV_DIVISOR = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } meter_state_t;

    // All-ones value for a counter of the given width; default TIMEOUT.
    function automatic int max_count(input int width);
        return (2 ** width) - 1;
    endfunction

    localparam int METER_TIMEOUT = max_count(METER_N);

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with a history flop, producing single-cycle
// rise/fall strobes and the synchronized level of an asynchronous input.
module edge_sync (
    input  logic clock_in,
    input  logic reset_n,
    input  logic signal_in,
    output logic rise,
    output logic fall,
    output logic level
);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] warm;

    // Until s2 holds a real sample, s3 copies s1 alongside s2 so that the
    // reset value of the pipeline never looks like an edge.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            warm <= 2'b00;
        end else begin
            s1   <= signal_in;
            s2   <= s1;
            s3   <= warm[1] ? s2 : s1;
            warm <= {warm[0], 1'b1};
        end
    end

    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
    assign level = s2;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow signal in clock_in cycles,
// flagging a timeout when no rising edge arrives within TIMEOUT cycles.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | no rise seen since reset; nothing to measure against
// ST_MEASURE | counting from the last rise; next rise reports a period
// ST_TIMEOUT | no rise for TIMEOUT cycles; next rise restarts, no report
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int N       = METER_N,
    parameter int TIMEOUT = max_count(N)
) (
    input  logic         clock_in,
    input  logic         reset_n,
    input  logic         signal_in,
    output logic [N-1:0] period_out,
    output logic [N-1:0] high_out,
    output logic         valid,
    output logic         timeout
);

    localparam logic [N-1:0] CNT_MAX = N'(TIMEOUT);

    logic         rise;
    logic         fall;
    logic         level;

    meter_state_t state;
    meter_state_t next_state;
    logic         load_result;

    logic [N-1:0] cnt;
    logic [N:0]   cnt_inc;
    logic [N-1:0] cnt_plus1;
    logic         at_limit;
    logic [N-1:0] high_latch;
    logic         fall_seen;

    edge_sync u_edge_sync (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .signal_in (signal_in),
        .rise      (rise),
        .fall      (fall),
        .level     (level)
    );

    // cnt never exceeds TIMEOUT, so the carry only appears at 2^N; clip it.
    assign cnt_inc   = {1'b0, cnt} + {{N{1'b0}}, 1'b1};
    assign cnt_plus1 = cnt_inc[N] ? {N{1'b1}} : cnt_inc[N-1:0];
    assign at_limit  = (cnt == CNT_MAX);

    always_comb begin
        next_state  = state;
        load_result = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rise) begin
                    next_state = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    load_result = 1'b1;
                end else if (at_limit) begin
                    next_state = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: begin
                if (rise) begin
                    next_state = ST_MEASURE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (!at_limit) begin
            cnt <= cnt_plus1;
        end
    end

    // Any low level after a rise means the falling edge happened; without
    // one the signal was high for the whole period.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            high_latch <= '0;
            fall_seen  <= 1'b0;
        end else begin
            if (fall && state == ST_MEASURE) begin
                high_latch <= cnt_plus1;
            end
            if (rise) begin
                fall_seen <= 1'b0;
            end else if (!level) begin
                fall_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid   <= load_result;
            timeout <= (next_state == ST_TIMEOUT);
            if (load_result) begin
                period_out <= cnt_plus1;
                high_out   <= fall_seen ? high_latch : cnt_plus1;
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: directed and random waveforms
// compared every cycle against an edge-event reference model.
module tb_clock_period_meter;

    localparam int N       = 8;
    localparam int TIMEOUT = 20;
    localparam int MAXV    = (2 ** N) - 1;
    localparam int LAT     = 3;

    logic         clock_in  = 1'b0;
    logic         reset_n   = 1'b0;
    logic         signal_in = 1'b0;
    logic [N-1:0] period_out;
    logic [N-1:0] high_out;
    logic         valid;
    logic         timeout;

    clock_period_meter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .signal_in  (signal_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout    (timeout)
    );

    always #5 clock_in = ~clock_in;

    // A driven transition, and the clock edge at which the meter acts on it.
    typedef struct packed {
        int   e;
        logic r;
    } ev_t;

    ev_t          evq[$];
    int           cyc       = 0;
    int           checks    = 0;
    int           errors    = 0;
    bit           have_prev = 1'b0;
    bit           fseen     = 1'b0;
    int           last_e    = 0;
    int           last_f    = 0;
    logic         exp_valid   = 1'b0;
    logic         exp_timeout = 1'b0;
    logic [N-1:0] exp_period  = '0;
    logic [N-1:0] exp_high    = '0;

    function automatic logic [N-1:0] clip(input int v);
        return (v > MAXV) ? N'(MAXV) : N'(v);
    endfunction

    // Expected outputs just after edge cyc, from the rise/fall edge times.
    task automatic model_step(input bit rst_seen);
        ev_t ev;
        int  p;
        exp_valid = 1'b0;
        if (rst_seen) begin
            have_prev  = 1'b0;
            fseen      = 1'b0;
            exp_period = '0;
            exp_high   = '0;
            evq.delete();
        end else begin
            while (evq.size() > 0 && evq[0].e <= cyc) begin
                ev = evq.pop_front();
                if (ev.r) begin
                    p = cyc - last_e;
                    if (have_prev && p <= TIMEOUT + 1) begin
                        exp_valid  = 1'b1;
                        exp_period = clip(p);
                        exp_high   = clip(fseen ? (last_f - last_e) : p);
                    end
                    have_prev = 1'b1;
                    last_e    = cyc;
                    fseen     = 1'b0;
                end else if (have_prev) begin
                    fseen  = 1'b1;
                    last_f = cyc;
                end
            end
        end
        exp_timeout = have_prev && ((cyc - last_e) > TIMEOUT);
    endtask

    task automatic check_outputs();
        checks++;
        assert (valid === exp_valid) else begin
            errors++;
            $error("FAIL valid cyc=%0d observed=%0b expected=%0b", cyc, valid, exp_valid);
        end
        checks++;
        assert (timeout === exp_timeout) else begin
            errors++;
            $error("FAIL timeout cyc=%0d observed=%0b expected=%0b", cyc, timeout, exp_timeout);
        end
        checks++;
        assert (period_out === exp_period) else begin
            errors++;
            $error("FAIL period_out cyc=%0d observed=%0d expected=%0d", cyc, period_out, exp_period);
        end
        checks++;
        assert (high_out === exp_high) else begin
            errors++;
            $error("FAIL high_out cyc=%0d observed=%0d expected=%0d", cyc, high_out, exp_high);
        end
    endtask

    task automatic tick(input logic sig, input logic rst);
        @(posedge clock_in);
        cyc++;
        model_step(!reset_n);
        #1;
        if (sig != signal_in) begin
            evq.push_back('{e: cyc + LAT, r: sig});
        end
        signal_in = sig;
        reset_n   = rst;
        @(negedge clock_in);
        check_outputs();
    endtask

    task automatic seg(input logic lvl, input int len);
        for (int i = 0; i < len; i++) begin
            tick(lvl, 1'b1);
        end
    endtask

    task automatic periods(input int hi, input int lo, input int count);
        for (int i = 0; i < count; i++) begin
            seg(1'b1, hi);
            seg(1'b0, lo);
        end
    endtask

    initial begin
        int hi;
        int lo;
        reset_n   = 1'b0;
        signal_in = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
        end
        seg(1'b0, 5);

        periods(2, 2, 8);      // divide-by-4, 50% duty
        periods(3, 7, 4);      // period 10, high 3
        periods(1, 1, 8);      // divide-by-2
        periods(4, 4, 3);      // period 8, then stop low past the timeout
        seg(1'b0, 30);
        periods(3, 4, 3);      // restart after timeout: first rise discarded
        periods(10, 11, 2);    // period 21 = TIMEOUT + 1, still reported
        periods(10, 12, 2);    // period 22 times out between rises

        // Reset in the middle of a long high phase, signal held high across it.
        seg(1'b0, 5);
        seg(1'b1, 6);
        tick(1'b1, 1'b0);
        seg(1'b1, 6);
        periods(5, 5, 3);

        for (int k = 0; k < 40; k++) begin
            hi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 25))
                                             : int'($urandom_range(1, 10));
            lo = ($urandom_range(0, 6) == 0) ? int'($urandom_range(15, 30))
                                             : int'($urandom_range(1, 10));
            periods(hi, lo, 1);
        end
        seg(1'b0, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
